// File: rtl/parity_serial_rx.sv
// Receiver for start/data/parity/stop frames: deserializes DATA_W bits LSB-first
// and reports data with parity and framing status on a one-cycle valid pulse.
module parity_serial_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              odd_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W) + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic              rx_meta_q, rx_s_q;
    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              p_q, p_d;
    logic              odd_q, odd_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;

    // Handshake: data_valid is a one-cycle strobe with no back-pressure; data_out,
    // parity_err and frame_err are stable from that cycle until the next strobe.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        p_d          = p_q;
        odd_d        = odd_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                    odd_d   = odd_sel;
                end
            end
            START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    // Shifting in at the MSB leaves the first-received bit at bit 0.
                    shift_d = (shift_q >> 1) | (DATA_W'(rx_s_q) << (DATA_W - 1));
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = '0;
                        state_d   = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    p_d     = rx_s_q;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    state_d      = DONE;
                    data_valid_d = 1'b1;
                    data_out_d   = shift_q;
                    parity_err_d = ((^shift_q) ^ p_q) != odd_q;
                    frame_err_d  = ~rx_s_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            p_q          <= 1'b0;
            odd_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            p_q          <= p_d;
            odd_q        <= odd_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_serial_rx.sv
// Bench for parity_serial_rx: table of frames with expected status, a scoreboard
// queue popped on every data_valid pulse, and hand-written glitch/reset sequences.
module tb_parity_serial_rx;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;
    localparam int W      = DATA_W + 2;
    localparam int NVEC   = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx;
    logic              odd_sel;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    typedef struct {
        logic [7:0] data;
        logic       p;
        logic       stop;
        logic       odd;
        int         gap;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t           vecs[NVEC];
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   mon_e;
    int             n_vec   = 0;
    int             n_bad   = 0;
    int             n_pulse = 0;
    int             n_push  = 0;

    always #5 clk = ~clk;

    parity_serial_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .odd_sel    (odd_sel),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // odd_sel is flipped right after the start bit; the frame must keep the latched sense.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input logic odd);
        odd_sel = odd;
        drive_bit(1'b0);
        odd_sel = ~odd;
        for (int i = 0; i < DATA_W; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic perr, input logic ferr);
        exp_q.push_back({d, perr, ferr});
        n_push++;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: %0d frames still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (data_valid) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse: data_out=%0h, expected no pulse", data_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("data_out", 16'(data_out), 16'(mon_e[W-1:2]));
                check("parity_err", 16'(parity_err), 16'(mon_e[1]));
                check("frame_err", 16'(frame_err), 16'(mon_e[0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // data, p, stop, odd, gap, exp_perr, exp_ferr
        vecs[0]  = '{8'hA5, 1'b0, 1'b1, 1'b0, 6, 1'b0, 1'b0};
        vecs[1]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 6, 1'b1, 1'b0};
        vecs[2]  = '{8'h07, 1'b0, 1'b1, 1'b1, 6, 1'b0, 1'b0};
        vecs[3]  = '{8'h07, 1'b1, 1'b1, 1'b1, 6, 1'b1, 1'b0};
        vecs[4]  = '{8'h3C, 1'b0, 1'b0, 1'b0, 6, 1'b0, 1'b1};
        vecs[5]  = '{8'h81, 1'b0, 1'b1, 1'b0, 6, 1'b0, 1'b0};
        vecs[6]  = '{8'h01, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[7]  = '{8'h02, 1'b1, 1'b1, 1'b0, 6, 1'b0, 1'b0};
        vecs[8]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b0};
        vecs[9]  = '{8'h00, 1'b0, 1'b1, 1'b1, 6, 1'b1, 1'b0};
        vecs[10] = '{8'hC3, 1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b1};
        vecs[11] = '{8'h80, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        vecs[12] = '{8'h55, 1'b1, 1'b1, 1'b0, 6, 1'b1, 1'b0};

        reset   = 1'b1;
        rx      = 1'b1;
        odd_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", 16'(data_out), 16'h0);
        check("reset_data_valid", 16'(data_valid), 16'h0);
        check("reset_parity_err", 16'(parity_err), 16'h0);
        check("reset_frame_err", 16'(frame_err), 16'h0);
        check("reset_busy", 16'(busy), 16'h0);
        reset = 1'b0;
        idle_clks(2);

        for (int i = 0; i < NVEC; i++) begin
            push_exp(vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr);
            send_frame(vecs[i].data, vecs[i].p, vecs[i].stop, vecs[i].odd);
            if (vecs[i].gap > 0) begin
                idle_clks(vecs[i].gap);
                wait_drain();
                idle_clks(2);
                check("hold_data_out", 16'(data_out), 16'(vecs[i].data));
                check("hold_parity_err", 16'(parity_err), 16'(vecs[i].exp_perr));
                check("hold_frame_err", 16'(frame_err), 16'(vecs[i].exp_ferr));
                check("hold_no_valid", 16'(data_valid), 16'h0);
                check("idle_busy", 16'(busy), 16'h0);
            end
        end

        // One-clock low glitch: START must reject it without a pulse.
        rx = 1'b0;
        idle_clks(1);
        rx = 1'b1;
        t = 0;
        while (!busy && t < 6) begin
            idle_clks(1);
            t++;
        end
        check("glitch_busy_rise", 16'(busy), 16'h1);
        t = 0;
        while (busy && t < 2 * CPB) begin
            idle_clks(1);
            t++;
        end
        check("glitch_busy_fall", 16'(busy), 16'h0);
        idle_clks(3 * CPB);

        // 0xFF frame aborted by reset during data bit 4; the line then stays idle.
        odd_sel = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        idle_clks(1);
        reset = 1'b1;
        idle_clks(1);
        reset = 1'b0;
        check("abort_data_out", 16'(data_out), 16'h0);
        check("abort_busy", 16'(busy), 16'h0);
        check("abort_data_valid", 16'(data_valid), 16'h0);
        check("abort_parity_err", 16'(parity_err), 16'h0);
        idle_clks(6 * CPB);
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        idle_clks(6);
        wait_drain();
        check("after_abort_data_out", 16'(data_out), 16'h5A);
        check("after_abort_parity_err", 16'(parity_err), 16'h0);

        idle_clks(4);
        check("pulse_count", 16'(n_pulse), 16'(n_push));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
